dbg_display: RTL and testbench

- Parametrised board debug monitor: N-digit multiplexed seven-segment scanner with debounced step/mode buttons and an internal browse address.
- Sits beside the CPU and data memory in the board top level.
- Drives `addr` to the data-memory read port and to the register-file select.
- Shows memory data, register data or the address itself, in hex.

---
 rtl/dbg_display_pkg.sv | 38 +++
 rtl/dbg_display_btn_debounce.sv | 53 +++++
 rtl/dbg_display.sv | 161 ++++++++++++++++
 tb/tb_dbg_display.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_display_pkg.sv
// Shared definitions for the dbg_display board debug monitor:
// view-mode encoding, blank segment pattern and the hex-to-segment decoder.
package dbg_display_pkg;

  typedef enum logic [1:0] {
    MODE_MEM  = 2'd0,
    MODE_GR   = 2'd1,
    MODE_ADDR = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dbg_display_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and a
// one-cycle press pulse on each accepted rising level.
module btn_debounce #(
  parameter int DEBOUNCE = 20000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any cycle where the synced input agrees with the accepted level restarts the count.
  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign level = level_q;
  assign press = level_d & ~level_q;

endmodule

// File: rtl/dbg_display.sv
// Board debug monitor: browse address, view mode and multiplexed hex display.
// Define DBG_DISPLAY_LZ_BLANK_EN to blank leading-zero digits.
//
// mode state | meaning
// MODE_MEM   | show mem_data for addr
// MODE_GR    | show gr_data for addr[GR_SEL_W-1:0]; add wraps inside the low field
// MODE_ADDR  | show addr itself
// MODE_RSVD  | unreachable; recovers to MODE_MEM
module dbg_display
  import dbg_display_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int GR_SEL_W = 3,
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 20000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_add,
  input  logic              btn_mode,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] gr_data,
  output logic [ADDR_W-1:0] addr,
  output logic [1:0]        mode,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg
);

  localparam int DISP_W = 4 * DIGITS;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W  = $clog2(SCAN_DIV);
  localparam logic [ADDR_W-1:0] GR_MASK = ADDR_W'((64'd1 << GR_SEL_W) - 64'd1);

  logic rst_s1_q, rst_s2_q, rst_n;
  logic add_press, mode_press, add_level, mode_level;
  logic unused_levels;

  mode_e             mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DISP_W-1:0] snap_q, snap_d, src;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              tick;

  // Assertion is immediate; release is re-timed to clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_s1_q <= 1'b0;
      rst_s2_q <= 1'b0;
    end else begin
      rst_s1_q <= 1'b1;
      rst_s2_q <= rst_s1_q;
    end
  end
  assign rst_n = rst_s2_q;

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_add (
    .clk    (clk),
    .reset  (rst_n),
    .btn_in (btn_add),
    .level  (add_level),
    .press  (add_press)
  );

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_mode (
    .clk    (clk),
    .reset  (rst_n),
    .btn_in (btn_mode),
    .level  (mode_level),
    .press  (mode_press)
  );

  assign unused_levels = add_level ^ mode_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_MEM;
      addr_q  <= '0;
      presc_q <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      an_q    <= '1;
      seg_q   <= SEG_BLANK;
    end else begin
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  // A mode press wins over a simultaneous add press.
  always_comb begin
    mode_d = mode_q;
    addr_d = addr_q;
    if (mode_press) begin
      case (mode_q)
        MODE_MEM: begin
          mode_d = MODE_GR;
          addr_d = addr_q & GR_MASK;
        end
        MODE_GR: mode_d = MODE_ADDR;
        default: mode_d = MODE_MEM;
      endcase
    end else if (add_press) begin
      if (mode_q == MODE_GR) begin
        addr_d = (addr_q & ~GR_MASK) | ((addr_q + ADDR_W'(1)) & GR_MASK);
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end
    if (mode_q == MODE_RSVD) begin
      mode_d = MODE_MEM;
    end
  end

  always_comb begin
    src = '0;
    case (mode_q)
      MODE_GR:   src[DATA_W-1:0] = gr_data;
      MODE_ADDR: src[ADDR_W-1:0] = addr_q;
      default:   src[DATA_W-1:0] = mem_data;
    endcase
  end

  // The slot that starts digit 0 also latches a fresh frame, so a frame never tears.
  always_comb begin
    tick    = (presc_q == PRE_W'(SCAN_DIV - 1));
    presc_d = tick ? '0 : presc_q + PRE_W'(1);
    idx_d   = idx_q;
    snap_d  = snap_q;
    an_d    = an_q;
    seg_d   = seg_q;
    if (tick) begin
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      if (idx_q == '0) begin
        snap_d = src;
      end
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = hex_to_seg(snap_d[{idx_q, 2'b00} +: 4]);
`ifdef DBG_DISPLAY_LZ_BLANK_EN
      if ((idx_q != '0) && ((snap_d >> {idx_q, 2'b00}) == '0)) begin
        seg_d = SEG_BLANK;
      end
`endif
    end
  end

  assign addr = addr_q;
  assign mode = mode_q;
  assign an   = an_q;
  assign seg  = seg_q;

endmodule

// File: tb/tb_dbg_display.sv
// Self-checking bench for dbg_display with a small scan/debounce configuration.
module tb_dbg_display;

  localparam int DIGITS   = 4;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 8;
  localparam int GR_SEL_W = 3;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              btn_add = 1'b0;
  logic              btn_mode = 1'b0;
  logic [DATA_W-1:0] mem_data = '0;
  logic [DATA_W-1:0] gr_data = '0;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        mode;
  logic [DIGITS-1:0] an;
  logic [6:0]        seg;

  int errors = 0;
  int checks = 0;
  int m_addr = 0;
  int m_mode = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  dbg_display #(
    .DIGITS(DIGITS), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .GR_SEL_W(GR_SEL_W), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_add  (btn_add),
    .btn_mode (btn_mode),
    .mem_data (mem_data),
    .gr_data  (gr_data),
    .addr     (addr),
    .mode     (mode),
    .an       (an),
    .seg      (seg)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] exp_seg(input logic [15:0] val, input int d);
    logic [15:0] hi;
    hi = val >> (4 * d);
`ifdef DBG_DISPLAY_LZ_BLANK_EN
    if (d != 0 && hi == 16'h0) return 7'h7F;
`endif
    return seg_tab[hi[3:0]];
  endfunction

  function automatic logic [15:0] model_src();
    if (m_mode == 1) return gr_data;
    if (m_mode == 2) return 16'(m_addr);
    return mem_data;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clean press/release of one or both buttons plus the model update it implies.
  task automatic press(input logic do_add, input logic do_mode);
    btn_add  = do_add;
    btn_mode = do_mode;
    cyc(DEBOUNCE + 4);
    btn_add  = 1'b0;
    btn_mode = 1'b0;
    cyc(DEBOUNCE + 4);
    if (do_mode) begin
      m_mode = (m_mode + 1) % 3;
      if (m_mode == 1) m_addr = m_addr % (1 << GR_SEL_W);
    end else if (do_add) begin
      if (m_mode == 1) m_addr = (m_addr & ~7) | ((m_addr + 1) & 7);
      else m_addr = (m_addr + 1) % 256;
    end
  endtask

  // Waits for the next frame start and checks all digits; optionally changes mem_data mid-frame.
  task automatic check_frame(input logic [15:0] val, input string tag,
                             input bit chg, input logic [15:0] nv);
    logic [3:0] prev;
    logic [3:0] exp_an;
    bit found;
    found = 1'b0;
    prev = an;
    for (int t = 0; t < 4 * SCAN_DIV * DIGITS + 8; t++) begin
      @(negedge clk);
      if (an == 4'hE && prev != 4'hE) begin
        found = 1'b1;
        break;
      end
      prev = an;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s frame_start: an=%h never entered E", tag, an);
      return;
    end
    for (int d = 0; d < DIGITS; d++) begin
      exp_an = ~(4'(1) << d);
      checks++;
      if (an !== exp_an) begin
        errors++;
        $display("FAIL %s an[d%0d]: got %h want %h", tag, d, an, exp_an);
      end
      checks++;
      if (seg !== exp_seg(val, d)) begin
        errors++;
        $display("FAIL %s seg[d%0d]: got %h want %h", tag, d, seg, exp_seg(val, d));
      end
      if (chg && d == 1) mem_data = nv;
      if (d < DIGITS - 1) cyc(SCAN_DIV);
    end
  endtask

  task automatic test_reset();
    int n;
    logic [3:0] exp_an;
    logic [6:0] exp_s;
    logic [15:0] v;
    reset = 1'b0;
    mem_data = 16'h12A0;
    cyc(3);
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an: got %h want f", an); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h want 7f", seg); end
    checks++; if (addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h want 00", addr); end
    checks++; if (mode !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d want 0", mode); end
    reset = 1'b1;
    n = 0;
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      if (an !== 4'hF) begin
        n = t;
        break;
      end
      checks++;
      if (seg !== 7'h7F) begin errors++; $display("FAIL pre_tick_seg: got %h want 7f", seg); end
    end
    checks++;
    if (n < SCAN_DIV || n > SCAN_DIV + 3) begin
      errors++;
      $display("FAIL first_tick: an left F after %0d cycles, want %0d..%0d", n, SCAN_DIV, SCAN_DIV + 3);
    end
    v = 16'h12A0;
    for (int k = 0; k <= DIGITS; k++) begin
      exp_an = ~(4'(1) << (k % DIGITS));
      exp_s  = seg_tab[(v >> (4 * (k % DIGITS))) & 16'hF];
      checks++;
      if (an !== exp_an) begin errors++; $display("FAIL scan_an[%0d]: got %h want %h", k, an, exp_an); end
      checks++;
      if (seg !== exp_s) begin errors++; $display("FAIL scan_seg[%0d]: got %h want %h", k, seg, exp_s); end
      cyc(SCAN_DIV);
    end
  endtask

  task automatic test_debounce();
    int n;
    btn_add = 1'b1;
    cyc(DEBOUNCE - 1);
    btn_add = 1'b0;
    cyc(12);
    checks++;
    if (addr !== 8'(m_addr)) begin errors++; $display("FAIL glitch_addr: got %h want %h", addr, 8'(m_addr)); end
    btn_add = 1'b1;
    n = 0;
    for (int t = 1; t <= 20; t++) begin
      @(posedge clk);
      #1;
      if (addr !== 8'(m_addr)) begin
        n = t;
        break;
      end
    end
    checks++;
    if (n != DEBOUNCE + 2) begin
      errors++;
      $display("FAIL press_latency: got %0d cycles want %0d", n, DEBOUNCE + 2);
    end
    @(negedge clk);
    cyc(6);
    btn_add = 1'b0;
    cyc(12);
    m_addr = (m_addr + 1) % 256;
    checks++;
    if (addr !== 8'(m_addr)) begin errors++; $display("FAIL single_inc: got %h want %h", addr, 8'(m_addr)); end
  endtask

  task automatic test_add_wrap();
    for (int i = 0; i < 256; i++) begin
      press(1'b1, 1'b0);
      checks++;
      if (addr !== 8'(m_addr)) begin
        errors++;
        $display("FAIL wrap_addr[%0d]: got %h want %h", i, addr, 8'(m_addr));
      end
    end
  endtask

  task automatic test_gr_mode();
    for (int i = 0; i < 256 && m_addr != 8'h2D; i++) press(1'b1, 1'b0);
    checks++;
    if (addr !== 8'h2D) begin errors++; $display("FAIL gr_setup: got %h want 2d", addr); end
    press(1'b0, 1'b1);
    checks++; if (mode !== 2'd1) begin errors++; $display("FAIL gr_mode: got %0d want 1", mode); end
    checks++; if (addr !== 8'h05) begin errors++; $display("FAIL gr_clear: got %h want 05", addr); end
    for (int i = 0; i < 3; i++) begin
      press(1'b1, 1'b0);
      checks++;
      if (addr !== 8'(m_addr)) begin errors++; $display("FAIL gr_add[%0d]: got %h want %h", i, addr, 8'(m_addr)); end
    end
    checks++; if (addr !== 8'h00) begin errors++; $display("FAIL gr_wrap: got %h want 00", addr); end
  endtask

  task automatic test_both();
    for (int i = 0; i < 2; i++) begin
      press(1'b1, 1'b1);
      checks++;
      if (mode !== 2'(m_mode)) begin errors++; $display("FAIL both_mode[%0d]: got %0d want %0d", i, mode, m_mode); end
      checks++;
      if (addr !== 8'(m_addr)) begin errors++; $display("FAIL both_addr[%0d]: got %h want %h", i, addr, 8'(m_addr)); end
    end
  endtask

  task automatic test_lz();
    while (m_mode != 2) press(1'b0, 1'b1);
    while (m_addr != 5) press(1'b1, 1'b0);
    checks++;
    if (mode !== 2'd2 || addr !== 8'h05) begin
      errors++;
      $display("FAIL lz_setup: mode %0d addr %h want 2 05", mode, addr);
    end
    check_frame(16'h0005, "lz", 1'b0, 16'h0);
  endtask

  task automatic test_tear();
    while (m_mode != 0) press(1'b0, 1'b1);
    mem_data = 16'hC3E9;
    check_frame(16'hC3E9, "tear_a", 1'b1, 16'h0040);
    check_frame(16'h0040, "tear_b", 1'b0, 16'h0);
  endtask

  task automatic test_random();
    int op;
    for (int it = 0; it < 10; it++) begin
      op = $urandom_range(0, 2);
      if (op == 0) press(1'b0, 1'b1);
      else if (op == 1) repeat ($urandom_range(1, 3)) press(1'b1, 1'b0);
      mem_data = 16'($urandom);
      gr_data  = 16'($urandom);
      if ($urandom_range(0, 1) == 1) mem_data = mem_data & 16'h00FF;
      checks++;
      if (mode !== 2'(m_mode) || addr !== 8'(m_addr)) begin
        errors++;
        $display("FAIL rnd_state[%0d]: mode %0d addr %h want %0d %h", it, mode, addr, m_mode, 8'(m_addr));
      end
      check_frame(model_src(), "rnd", 1'b0, 16'h0);
    end
  endtask

  task automatic test_mid_reset();
    if (m_addr == 0) press(1'b1, 1'b0);
    cyc(5);
    #2;
    reset = 1'b0;
    #1;
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL midrst_an: got %h want f", an); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL midrst_seg: got %h want 7f", seg); end
    checks++; if (addr !== 8'h00) begin errors++; $display("FAIL midrst_addr: got %h want 00", addr); end
    checks++; if (mode !== 2'd0) begin errors++; $display("FAIL midrst_mode: got %0d want 0", mode); end
    m_addr = 0;
    m_mode = 0;
    cyc(3);
    reset = 1'b1;
    cyc(3);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_debounce();
    test_add_wrap();
    test_gr_mode();
    test_both();
    test_lz();
    test_tear();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
